// File: rtl/reorder_buffer.sv
// 16-entry in-order retirement buffer with exception flush.
// Optional combinational forwarding port enabled by defining ROB_FORWARD_EN.
module reorder_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        alloc_en,
    input  logic        alloc_dest_en,
    input  logic [4:0]  alloc_addr,
    output logic [3:0]  alloc_ref_id,
    output logic        full,
    input  logic        wb_en,
    input  logic [3:0]  wb_ref_id,
    input  logic [31:0] wb_data,
    input  logic        wb_exc,
    output logic        commit_en,
    output logic        commit_restore,
    output logic [4:0]  commit_addr,
    output logic [31:0] commit_data,
    input  logic [3:0]  read_ref_id,
    output logic        read_ready,
    output logic [31:0] read_data
);

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  done;
    logic [DEPTH-1:0]  exc;
    logic [DEPTH-1:0]  dest_en;
    logic [ADDR_W-1:0] addr [DEPTH];
    logic [DATA_W-1:0] data [DEPTH];
    logic [ID_W-1:0]   head;
    logic [ID_W-1:0]   tail;
    logic [CNT_W-1:0]  count;

    logic head_ready;
    logic do_retire;
    logic do_flush;
    logic do_alloc;
    logic do_wb;

    // Commit decisions look only at registered done, never at this cycle's writeback.
    assign head_ready   = valid[head] & done[head];
    assign full         = (count == CNT_W'(DEPTH)) || (state == FLUSH);
    assign alloc_ref_id = tail;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (head_ready && exc[head]) state_next = FLUSH;
            FLUSH:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Flush overrides any allocation or writeback in the same cycle.
    always_comb begin
        do_retire = 1'b0;
        do_flush  = 1'b0;
        do_alloc  = 1'b0;
        do_wb     = 1'b0;
        if (state == RUN) begin
            do_retire = head_ready & ~exc[head];
            do_flush  = head_ready & exc[head];
            do_alloc  = alloc_en & ~full & ~do_flush;
            do_wb     = wb_en & valid[wb_ref_id] & ~do_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
            done  <= '0;
            exc   <= '0;
        end else if (do_flush) begin
            valid <= '0;
        end else begin
            if (do_wb) begin
                done[wb_ref_id] <= 1'b1;
                exc[wb_ref_id]  <= wb_exc;
            end
            if (do_retire) begin
                valid[head] <= 1'b0;
            end
            if (do_alloc) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                exc[tail]   <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset; valid gates every use.
    always_ff @(posedge clk) begin
        if (do_wb) begin
            data[wb_ref_id] <= wb_data;
        end
        if (do_alloc) begin
            addr[tail]    <= alloc_addr;
            dest_en[tail] <= alloc_dest_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || do_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_retire) head <= head + ID_W'(1);
            if (do_alloc)  tail <= tail + ID_W'(1);
            count <= count + CNT_W'(do_alloc) - CNT_W'(do_retire);
        end
    end

    // Commit outputs are zero in any cycle without a retirement.
    always_ff @(posedge clk) begin
        if (!rst) begin
            commit_en      <= 1'b0;
            commit_restore <= 1'b0;
            commit_addr    <= '0;
            commit_data    <= '0;
        end else begin
            commit_en      <= do_retire & dest_en[head];
            commit_restore <= do_flush;
            commit_addr    <= do_retire ? addr[head] : '0;
            commit_data    <= do_retire ? data[head] : '0;
        end
    end

`ifdef ROB_FORWARD_EN
    assign read_ready = valid[read_ref_id] & done[read_ref_id];
    assign read_data  = data[read_ref_id];
`else
    logic unused_read;
    assign read_ready  = 1'b0;
    assign read_data   = '0;
    assign unused_read = ^read_ref_id;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based model predicts every commit/restore
// (value and cycle); a negedge monitor matches DUT output against those predictions.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_en;
    logic        alloc_dest_en;
    logic [4:0]  alloc_addr;
    logic [3:0]  alloc_ref_id;
    logic        full;
    logic        wb_en;
    logic [3:0]  wb_ref_id;
    logic [31:0] wb_data;
    logic        wb_exc;
    logic        commit_en;
    logic        commit_restore;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;
    logic [3:0]  read_ref_id;
    logic        read_ready;
    logic [31:0] read_data;

    reorder_buffer dut (
        .clk(clk), .rst(rst),
        .alloc_en(alloc_en), .alloc_dest_en(alloc_dest_en), .alloc_addr(alloc_addr),
        .alloc_ref_id(alloc_ref_id), .full(full),
        .wb_en(wb_en), .wb_ref_id(wb_ref_id), .wb_data(wb_data), .wb_exc(wb_exc),
        .commit_en(commit_en), .commit_restore(commit_restore),
        .commit_addr(commit_addr), .commit_data(commit_data),
        .read_ref_id(read_ref_id), .read_ready(read_ready), .read_data(read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int        id;
        bit        dest;
        bit [4:0]  addr;
        bit        done;
        bit        exc;
        bit [31:0] data;
    } ent_t;

    typedef struct {
        int        cyc;
        bit        en;
        bit        restore;
        bit [4:0]  addr;
        bit [31:0] data;
    } exp_t;

    ent_t rob_q[$];
    exp_t exp_q[$];
    int   next_id  = 0;
    bit   in_flush = 1'b0;
    int   cyc      = 0;
    int   tests    = 0;
    int   failed   = 0;
    int   ncommit  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model of one clock edge given the inputs currently applied.
    task automatic model_edge(input bit r, input bit a, input bit ad, input bit [4:0] aa,
                              input bit w, input bit [3:0] wid, input bit [31:0] wd,
                              input bit we);
        bit   full_pre;
        bit   flushed;
        ent_t e;
        exp_t x;
        if (!r) begin
            rob_q.delete();
            next_id  = 0;
            in_flush = 1'b0;
            return;
        end
        if (in_flush) begin
            in_flush = 1'b0;
            return;
        end
        full_pre = (rob_q.size() == 16);
        flushed  = 1'b0;
        if (rob_q.size() > 0 && rob_q[0].done) begin
            if (rob_q[0].exc) begin
                rob_q.delete();
                next_id   = 0;
                in_flush  = 1'b1;
                flushed   = 1'b1;
                x.cyc     = cyc + 1;
                x.en      = 1'b0;
                x.restore = 1'b1;
                x.addr    = '0;
                x.data    = '0;
                exp_q.push_back(x);
            end else begin
                e         = rob_q.pop_front();
                x.cyc     = cyc + 1;
                x.en      = e.dest;
                x.restore = 1'b0;
                x.addr    = e.addr;
                x.data    = e.data;
                exp_q.push_back(x);
            end
        end
        if (flushed) return;
        if (w) begin
            foreach (rob_q[k]) begin
                if (rob_q[k].id == int'(wid)) begin
                    rob_q[k].done = 1'b1;
                    rob_q[k].exc  = we;
                    rob_q[k].data = wd;
                end
            end
        end
        if (a && !full_pre) begin
            e.id   = next_id;
            e.dest = ad;
            e.addr = aa;
            e.done = 1'b0;
            e.exc  = 1'b0;
            e.data = '0;
            rob_q.push_back(e);
            next_id = (next_id + 1) % 16;
        end
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic step(input bit r, input bit a, input bit ad, input bit [4:0] aa,
                        input bit w, input bit [3:0] wid, input bit [31:0] wd, input bit we);
        bit        fwd_ready;
        bit [31:0] fwd_data;
        rst           = r;
        alloc_en      = a;
        alloc_dest_en = ad;
        alloc_addr    = aa;
        wb_en         = w;
        wb_ref_id     = wid;
        wb_data       = wd;
        wb_exc        = we;
        read_ref_id   = 4'($urandom);
        #1;
        check("alloc_ref_id", 32'(alloc_ref_id), 32'(next_id));
        check("full", 32'(full), 32'((rob_q.size() == 16) || in_flush));
        fwd_ready = 1'b0;
        fwd_data  = '0;
        foreach (rob_q[k]) begin
            if (rob_q[k].id == int'(read_ref_id) && rob_q[k].done) begin
                fwd_ready = 1'b1;
                fwd_data  = rob_q[k].data;
            end
        end
`ifdef ROB_FORWARD_EN
        check("read_ready", 32'(read_ready), 32'(fwd_ready));
        if (fwd_ready) check("read_data", read_data, fwd_data);
`else
        check("read_ready_tied", 32'(read_ready), 32'(1'b0));
        check("read_data_tied", read_data, 32'(fwd_data & 32'h0));
`endif
        model_edge(r, a, ad, aa, w, wid, wd, we);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1, 0, 0, 5'd0, 0, 4'd0, 32'd0, 0);
    endtask

    task automatic alloc(input bit [4:0] aa);
        step(1, 1, 1, aa, 0, 4'd0, 32'd0, 0);
    endtask

    task automatic wb(input bit [3:0] id, input bit [31:0] d, input bit e);
        step(1, 0, 0, 5'd0, 1, id, d, e);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 5'd0, 0, 4'd0, 32'd0, 0);
    endtask

    // Monitor: every observed commit/restore must match the oldest prediction and its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (commit_en !== 1'b0 || commit_restore !== 1'b0 ||
            commit_addr !== 5'd0 || commit_data !== 32'd0) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_commit at cycle %0d: en=%0b restore=%0b addr=%0h data=%0h, nothing expected",
                         cyc, commit_en, commit_restore, commit_addr, commit_data);
            end else begin
                e = exp_q.pop_front();
                check("commit_cycle", 32'(cyc), 32'(e.cyc));
                check("commit_en", 32'(commit_en), 32'(e.en));
                check("commit_restore", 32'(commit_restore), 32'(e.restore));
                check("commit_addr", 32'(commit_addr), 32'(e.addr));
                check("commit_data", commit_data, e.data);
                if (commit_en === 1'b1) ncommit++;
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            tests++;
            failed++;
            $display("FAIL missing_commit at cycle %0d: got nothing, expected en=%0b restore=%0b addr=%0h data=%0h",
                     cyc, e.en, e.restore, e.addr, e.data);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int        n0;
        bit        r;
        bit        a;
        bit        w;
        bit        we;
        bit [3:0]  wid;
        int        cand[$];
        rst = 1'b0; alloc_en = 0; alloc_dest_en = 0; alloc_addr = '0;
        wb_en = 0; wb_ref_id = '0; wb_data = '0; wb_exc = 0; read_ref_id = '0;
        @(negedge clk);
        do_reset();
        check("reset_commit_en", 32'(commit_en), 32'd0);
        check("reset_restore", 32'(commit_restore), 32'd0);
        check("reset_ref_id", 32'(alloc_ref_id), 32'd0);
        check("reset_full", 32'(full), 32'd0);

        // Single commit, two cycles after the writeback
        alloc(5'd1);
        wb(4'd0, 32'h12345678, 0);
        idle();
        check("basic_commit_en", 32'(commit_en), 32'd1);
        check("basic_commit_addr", 32'(commit_addr), 32'd1);
        check("basic_commit_data", commit_data, 32'h12345678);

        // Fill to 16, overflow alloc ignored, one retirement frees a slot
        do_reset();
        for (int i = 0; i < 16; i++) alloc(5'(i));
        check("full_at_16", 32'(full), 32'd1);
        check("ref_id_wrapped", 32'(alloc_ref_id), 32'd0);
        alloc(5'd31);
        check("ref_id_after_17th", 32'(alloc_ref_id), 32'd0);
        wb(4'd0, 32'h55, 0);
        idle();
        check("full_after_retire", 32'(full), 32'd0);

        // Out-of-order completion retires in order
        do_reset();
        alloc(5'd3);
        alloc(5'd4);
        wb(4'd1, 32'habcdef00, 0);
        wb(4'd0, 32'h1, 0);
        idle();
        check("ooo_first", commit_data, 32'h1);
        idle();
        check("ooo_second", commit_data, 32'habcdef00);

        // Exception flush
        do_reset();
        alloc(5'd7);
        wb(4'd0, 32'hdead, 1);
        idle();
        check("exc_restore", 32'(commit_restore), 32'd1);
        check("exc_commit_en", 32'(commit_en), 32'd0);
        check("exc_full_in_flush", 32'(full), 32'd1);
        idle();
        check("exc_restore_one_cycle", 32'(commit_restore), 32'd0);
        check("exc_ref_id", 32'(alloc_ref_id), 32'd0);
        check("exc_full_after", 32'(full), 32'd0);

        // Tail wraps: 20 pipelined alloc/writeback pairs
        do_reset();
        n0 = ncommit;
        for (int i = 0; i < 20; i++)
            step(1, 1, 1, 5'(i + 1), i > 0, 4'(i - 1), 32'hc000_0000 + 32'(i - 1), 0);
        wb(4'd3, 32'hc000_0013, 0);
        idle(); idle(); idle();
        check("wrap_commit_count", 32'(ncommit - n0), 32'd20);

        // Mid-operation reset drops everything
        do_reset();
        for (int i = 0; i < 5; i++) alloc(5'(i + 8));
        wb(4'd0, 32'h77, 0);
        do_reset();
        check("midrst_commit_en", 32'(commit_en), 32'd0);
        check("midrst_addr", 32'(commit_addr), 32'd0);
        check("midrst_data", commit_data, 32'd0);
        check("midrst_ref_id", 32'(alloc_ref_id), 32'd0);
        wb(4'd2, 32'h99, 0);
        idle(); idle();
        check("midrst_no_commit", 32'(commit_en), 32'd0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            r  = ($urandom_range(0, 299) != 0);
            a  = ((n / 250) % 2 == 1) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 4);
            w  = ($urandom_range(0, 1) == 1);
            we = ($urandom_range(0, 39) == 0);
            cand.delete();
            foreach (rob_q[k]) if (!rob_q[k].done) cand.push_back(rob_q[k].id);
            if (cand.size() > 0 && $urandom_range(0, 9) < 8)
                wid = 4'(cand[$urandom_range(0, cand.size() - 1)]);
            else
                wid = 4'($urandom);
            step(r, a, 1'($urandom), 5'($urandom), w, wid, $urandom | 32'h1, we);
        end

        // Drain outstanding entries
        for (int n = 0; n < 40; n++) begin
            cand.delete();
            foreach (rob_q[k]) if (!rob_q[k].done) cand.push_back(rob_q[k].id);
            if (cand.size() > 0) wb(4'(cand[0]), $urandom | 32'h1, 0);
            else idle();
        end
        idle();
        #2;
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port alloc_en, input, 1 bit: allocate one entry at the tail.
REQ-004 SHALL have port alloc_dest_en, input, 1 bit: the allocated instruction writes a GPR.
REQ-005 SHALL have port alloc_addr, input, `RF_ADDR_BUS (5): destination register number.
REQ-006 SHALL have port alloc_ref_id, output, `ROB_ADDR_BUS (4): id of the entry being allocated, equal to the tail pointer (combinational).
REQ-007 SHALL have port full, output, 1 bit: no entry free, or FLUSH state active.
REQ-008 SHALL have port wb_en, input, 1 bit: writeback valid.
REQ-009 SHALL have port wb_ref_id, input, `ROB_ADDR_BUS: target entry of the writeback.
REQ-010 SHALL have port wb_data, input, `DATA_BUS (32): result value.
REQ-011 SHALL have port wb_exc, input, 1 bit: the instruction raised an exception.
REQ-012 SHALL have port commit_en, output, 1 bit: register-file commit strobe.
REQ-013 SHALL have port commit_restore, output, 1 bit: register file drops all ref ids.
REQ-014 SHALL have port commit_addr, output, `RF_ADDR_BUS: destination register of the commit.
REQ-015 SHALL have port commit_data, output, `DATA_BUS: value being committed.
REQ-016 SHALL have port read_ref_id, input, `ROB_ADDR_BUS: forwarding lookup id (ROB_FORWARD_EN only).
REQ-017 SHALL have port read_ready, output, 1 bit: the looked-up entry is valid and done (ROB_FORWARD_EN only).
REQ-018 SHALL have port read_data, output, `DATA_BUS: data of the looked-up entry (ROB_FORWARD_EN only).

Function
REQ-019 SHALL hold 16 entries in a circular buffer; each entry holds valid, done, exc, dest_en, addr and data; head, tail and a 5-bit count are kept.
REQ-020 SHALL allocate when alloc_en=1 and full=0: set entry[tail] valid=1, done=0, exc=0; latch dest_en and addr; tail advances and wraps 15->0.
REQ-021 SHALL ignore alloc_en while full=1; tail and count stay unchanged.
REQ-022 SHALL assert full exactly when count==16 or the state is FLUSH.
REQ-023 SHALL, on wb_en to a valid entry, set done=1, store data and set exc=wb_exc; a writeback to an invalid entry is ignored.
REQ-024 SHALL evaluate commit against registered done only; a writeback arriving in the same cycle is committable one cycle later.
REQ-025 SHALL retire at most one entry per cycle, in order; entries done out of order wait until all older entries have retired.
REQ-026 SHALL, when entry[head] is valid, done and exc=0, clear it and advance head, and in the next cycle drive commit_en=dest_en, commit_addr=addr and commit_data=data.
REQ-027 SHALL register commit outputs; they hold zero in every cycle that has no retirement.
REQ-028 SHALL keep count correct when allocation and retirement occur in the same cycle; count is unchanged and allocation is allowed if count was below 16.
REQ-029 SHALL implement an FSM with two states: RUN and FLUSH.
REQ-030 SHALL, in RUN, on reaching a head entry with valid, done and exc=1, invalidate all entries, set head=tail=count=0, go to FLUSH and drive commit_en=0 for that entry.
REQ-031 SHALL, in FLUSH, drive commit_restore=1 for exactly one cycle, ignore alloc and wb, and return to RUN.

Reset
REQ-032 SHALL, with rst=0 at a clock edge, clear all valid bits and set head=tail=count=0, state=RUN, and commit_en=commit_restore=0, commit_addr=0, commit_data=0; this applies even mid-operation.
REQ-033 SHALL, after reset, show alloc_ref_id=0 and full=0.

Configuration
REQ-034 SHALL, with ROB_FORWARD_EN defined, drive read_ready and read_data combinationally from entry[read_ref_id], so a same-cycle writeback is not visible until the next cycle.
REQ-035 SHALL, with ROB_FORWARD_EN undefined, tie read_ready=0 and read_data=0 and ignore read_ref_id.

Verification
REQ-036 SHALL cover: alloc addr=1, then wb id 0 with data 0x12345678 -> two cycles after the wb, commit_en=1, commit_addr=1, commit_data=0x12345678.
REQ-037 SHALL cover: 16 allocs -> full=1 and a 17th alloc ignored (alloc_ref_id stays 0); one retirement -> full=0.
REQ-038 SHALL cover: wb id 1 (0xabcdef00) before id 0 (0x1) -> commits in order, 0x1 then 0xabcdef00, in consecutive cycles.
REQ-039 SHALL cover: wb id 0 with wb_exc=1 -> commit_restore=1 for one cycle, commit_en=0, then alloc_ref_id=0 and count=0.
REQ-040 SHALL cover: tail wraps 15->0 across a full allocate-and-retire cycle -> all 20 commits in order with correct data.
REQ-041 SHALL cover: rst=0 with 5 entries outstanding -> all outputs zero next cycle, and a later writeback to id 2 produces no commit.
